// File: rtl/bpsk_fifo_pkg.sv
// Shared definitions for the BPSK datapath FIFO: read-mode constants, the
// acceptance encoding used by the occupancy update, and parameter helpers.
package bpsk_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Which requests were accepted this cycle: {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Address width of the storage array (pointer width without the wrap bit).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // Legal parameter combination for sync_fifo_ctl.
  function automatic bit fifo_params_ok(input int depth, input int fwft,
                                        input int af_level, input int ae_level);
    return is_pow2(depth)
        && ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT))
        && (af_level >= 1) && (af_level <= depth)
        && (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage : bpsk_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array with one synchronous write port
// and one asynchronous (combinational) read port.
module sync_fifo_mem
  import bpsk_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk_sig,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address on an accepted write.
  // NOTE: the array has no reset on purpose -- the pointers alone define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_sig) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port is combinational so FWFT mode can present the head word directly.
  assign rd_data = mem_q[rd_addr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_ctl.sv
// Synchronous FIFO controller for the BPSK datapath: wrap-bit pointers,
// occupancy count, almost-full/empty thresholds, standard or first-word-
// fall-through read mode, and sticky overflow/underflow flags.
module sync_fifo_ctl
  import bpsk_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk_sig,
  input  logic                   rst_sig,
  input  logic                   w_en_sig,
  input  logic                   r_en_sig,
  input  logic                   clr_err_sig,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

  // Reject illegal parameter sets while elaborating.
  if (!fifo_params_ok(DEPTH, FWFT, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo_ctl: illegal parameters DEPTH=%0d FWFT=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, FWFT, AF_LEVEL, AE_LEVEL);
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   w_ptr_q, w_ptr_d;
  logic [PTR_W:0]   r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_c, empty_c;
  logic             w_acc, r_acc;
  fifo_op_e         op;
  logic [WIDTH-1:0] rd_data;

  // Storage array; written only on accepted writes, read at the read pointer.
  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_sig (clk_sig),
    .wr_en   (w_acc),
    .wr_addr (w_ptr_q[PTR_W-1:0]),
    .wr_data (data_in),
    .rd_addr (r_ptr_q[PTR_W-1:0]),
    .rd_data (rd_data)
  );

  // Status flags from the registered pointers, and request acceptance. A
  // same-cycle read never makes room for a write when full, and a same-cycle
  // write never supplies a read when empty.
  always_comb begin
    full_c  = (w_ptr_q[PTR_W] != r_ptr_q[PTR_W])
           && (w_ptr_q[PTR_W-1:0] == r_ptr_q[PTR_W-1:0]);
    empty_c = (w_ptr_q == r_ptr_q);
    w_acc   = w_en_sig & ~full_c;
    r_acc   = r_en_sig & ~empty_c;
    op      = fifo_op_e'({w_acc, r_acc});
  end

  // Next-state for pointers, occupancy, read register and error flags.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (w_acc) begin
      w_ptr_d = w_ptr_q + 1'b1;
    end
    if (r_acc) begin
      r_ptr_d  = r_ptr_q + 1'b1;
      dout_d   = rd_data;
      dvalid_d = 1'b1;
    end

    case (op)
      OP_WRITE: count_d = count_q + 1'b1;
      OP_READ:  count_d = count_q - 1'b1;
      default:  count_d = count_q;
    endcase

    // A set condition outranks a same-cycle clear.
    if (w_en_sig && full_c) begin
      overflow_d = 1'b1;
    end else if (clr_err_sig) begin
      overflow_d = 1'b0;
    end
    if (r_en_sig && empty_c) begin
      underflow_d = 1'b1;
    end else if (clr_err_sig) begin
      underflow_d = 1'b0;
    end
  end

  // State registers; synchronous reset overrides every other input.
  always_ff @(posedge clk_sig) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (rst_sig) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Standard mode shows the registered read word; FWFT shows the head directly.
  assign data_out     = (FWFT == FIFO_MODE_STD) ? dout_q   : rd_data;
  assign data_valid   = (FWFT == FIFO_MODE_STD) ? dvalid_q : ~empty_c;
  assign full         = full_c;
  assign empty        = empty_c;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : sync_fifo_ctl

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: a standard-mode and an FWFT instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_ctl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk_sig     = 1'b0;
  logic             rst_sig     = 1'b1;
  logic             w_en_sig    = 1'b0;
  logic             r_en_sig    = 1'b0;
  logic             clr_err_sig = 1'b0;
  logic [WIDTH-1:0] data_in     = '0;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic             f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]       s_cnt, f_cnt;

  always #5 clk_sig = ~clk_sig;

  sync_fifo_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_std (
    .clk_sig(clk_sig), .rst_sig(rst_sig), .w_en_sig(w_en_sig), .r_en_sig(r_en_sig),
    .clr_err_sig(clr_err_sig), .data_in(data_in), .data_out(s_dout), .data_valid(s_dv),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_fwft (
    .clk_sig(clk_sig), .rst_sig(rst_sig), .w_en_sig(w_en_sig), .r_en_sig(r_en_sig),
    .clr_err_sig(clr_err_sig), .data_in(data_in), .data_out(f_dout), .data_valid(f_dv),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

  int total = 0;
  int bad   = 0;

  // Reference model: scoreboard queue of stored words plus error/read state.
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv, m_ovf, m_unf;
  logic [3:0]       m_wptr, m_rptr;

  // Expected {count, full, empty, almost_full, almost_empty} from the model.
  function automatic logic [7:0] m_status();
    int n;
    n = sb.size();
    return {4'(n), n == DEPTH, n == 0, n >= 6, n <= 2};
  endfunction

  function automatic logic [7:0] s_status();
    return {s_cnt, s_full, s_empty, s_af, s_ae};
  endfunction

  function automatic logic [7:0] f_status();
    return {f_cnt, f_full, f_empty, f_af, f_ae};
  endfunction

  // One clock with the given requests; the model is updated from pre-edge state.
  task automatic tick(input logic we, input logic re, input logic clr,
                      input logic [WIDTH-1:0] din);
    bit m_full, m_empty;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    w_en_sig = we; r_en_sig = re; clr_err_sig = clr; data_in = din;
    if (we && m_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (re && m_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    m_dv = 1'b0;
    if (re && !m_empty) begin
      m_dout = sb.pop_front();
      m_dv   = 1'b1;
      m_rptr = m_rptr + 4'd1;
    end
    if (we && !m_full) begin
      sb.push_back(din);
      m_wptr = m_wptr + 4'd1;
    end
    @(posedge clk_sig);
    #1;
    w_en_sig = 1'b0; r_en_sig = 1'b0; clr_err_sig = 1'b0;
  endtask

  // One clock with reset asserted, optionally alongside a write request.
  task automatic tick_rst(input logic we);
    rst_sig = 1'b1; w_en_sig = we; data_in = 8'hEE;
    sb.delete();
    m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_wptr = '0; m_rptr = '0;
    @(posedge clk_sig);
    #1;
    rst_sig = 1'b0; w_en_sig = 1'b0;
  endtask

  task automatic test_reset();
    tick_rst(1'b0);
    total++;
    if (s_status() !== 8'h05) begin
      bad++; $display("FAIL reset_status_std: got %h want %h", s_status(), 8'h05);
    end
    total++;
    if ({s_dout, s_dv, s_ovf, s_unf} !== 11'h000) begin
      bad++; $display("FAIL reset_out_std: got %h want %h", {s_dout, s_dv, s_ovf, s_unf}, 11'h000);
    end
    total++;
    if ({f_status(), f_dv, f_ovf, f_unf} !== {8'h05, 3'b000}) begin
      bad++; $display("FAIL reset_fwft: got %h want %h", {f_status(), f_dv, f_ovf, f_unf}, {8'h05, 3'b000});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)));
      total++;
      if (s_status() !== m_status()) begin
        bad++; $display("FAIL fill_status[%0d]: got %h want %h", i, s_status(), m_status());
      end
      total++;
      if ({f_dv, f_dout} !== {1'b1, 8'h11}) begin
        bad++; $display("FAIL fill_fwft_head[%0d]: got %h want %h", i, {f_dv, f_dout}, {1'b1, 8'h11});
      end
    end
    total++;
    if (s_status() !== 8'h8A) begin
      bad++; $display("FAIL fill_full: got %h want %h", s_status(), 8'h8A);
    end
    tick(1'b1, 1'b0, 1'b0, 8'h99);
    total++;
    if ({s_cnt, s_ovf, s_full, f_ovf} !== {4'd8, m_ovf, 1'b1, 1'b1}) begin
      bad++; $display("FAIL fill_overflow: got %h want %h", {s_cnt, s_ovf, s_full, f_ovf}, {4'd8, m_ovf, 1'b1, 1'b1});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if ({s_dv, s_dout} !== {m_dv, m_dout}) begin
        bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, {s_dv, s_dout}, {m_dv, m_dout});
      end
      total++;
      if (s_status() !== m_status()) begin
        bad++; $display("FAIL drain_status[%0d]: got %h want %h", i, s_status(), m_status());
      end
      if (sb.size() > 0) begin
        total++;
        if ({f_dv, f_dout} !== {1'b1, sb[0]}) begin
          bad++; $display("FAIL drain_fwft[%0d]: got %h want %h", i, {f_dv, f_dout}, {1'b1, sb[0]});
        end
      end
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if ({s_dv, s_dout, f_dv} !== {1'b0, 8'h88, 1'b0}) begin
      bad++; $display("FAIL drain_hold: got %h want %h", {s_dv, s_dout, f_dv}, {1'b0, 8'h88, 1'b0});
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if ({s_unf, f_unf, s_dv, s_cnt} !== {m_unf, 1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL drain_underflow: got %h want %h", {s_unf, f_unf, s_dv, s_cnt}, {m_unf, 1'b1, 1'b0, 4'd0});
    end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    total++;
    if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0000) begin
      bad++; $display("FAIL clear_errors: got %b want %b", {s_ovf, s_unf, f_ovf, f_unf}, 4'b0000);
    end
  endtask

  task automatic test_fwft();
    tick(1'b1, 1'b0, 1'b0, 8'hA5);
    total++;
    if ({f_dv, f_dout, s_dv} !== {1'b1, 8'hA5, 1'b0}) begin
      bad++; $display("FAIL fwft_show: got %h want %h", {f_dv, f_dout, s_dv}, {1'b1, 8'hA5, 1'b0});
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if ({f_empty, f_dv, s_dv, s_dout} !== {1'b1, 1'b0, 1'b1, 8'hA5}) begin
      bad++; $display("FAIL fwft_pop: got %h want %h", {f_empty, f_dv, s_dv, s_dout}, {1'b1, 1'b0, 1'b1, 8'hA5});
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      total++;
      if ({s_cnt, s_dv, s_dout} !== {4'd4, m_dv, m_dout}) begin
        bad++; $display("FAIL rw_mid[%0d]: got %h want %h", i, {s_cnt, s_dv, s_dout}, {4'd4, m_dv, m_dout});
      end
    end
    for (int i = 0; i < DEPTH && sb.size() < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    tick(1'b1, 1'b1, 1'b0, 8'hEE);
    total++;
    if ({s_cnt, s_ovf, s_dv, s_dout} !== {4'd7, 1'b1, m_dv, m_dout}) begin
      bad++; $display("FAIL rw_full: got %h want %h", {s_cnt, s_ovf, s_dv, s_dout}, {4'd7, 1'b1, m_dv, m_dout});
    end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if ({s_dv, s_dout} !== {m_dv, m_dout}) begin
        bad++; $display("FAIL rw_order[%0d]: got %h want %h", i, {s_dv, s_dout}, {m_dv, m_dout});
      end
    end
    tick(1'b1, 1'b1, 1'b0, 8'h77);
    total++;
    if ({s_cnt, s_unf, s_dv, f_dv, f_dout} !== {4'd1, 1'b1, 1'b0, 1'b1, 8'h77}) begin
      bad++; $display("FAIL rw_empty: got %h want %h", {s_cnt, s_unf, s_dv, f_dv, f_dout}, {4'd1, 1'b1, 1'b0, 1'b1, 8'h77});
    end
    tick(1'b0, 1'b1, 1'b1, 8'h00);
    total++;
    if ({s_dout, s_unf, s_empty} !== {m_dout, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rw_empty_drain: got %h want %h", {s_dout, s_unf, s_empty}, {m_dout, 1'b0, 1'b1});
    end
  endtask

  task automatic test_wrap();
    int  off;
    logic prev_wrap;
    logic saw_toggle;
    tick_rst(1'b0);
    off = $urandom_range(1, 7);
    for (int i = 0; i < off; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      tick(1'b0, 1'b1, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'hD0 + i));
    prev_wrap  = u_std.w_ptr_q[3];
    saw_toggle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      if (u_std.w_ptr_q[3] !== prev_wrap) saw_toggle = 1'b1;
      prev_wrap = u_std.w_ptr_q[3];
      total++;
      if ({s_dv, s_dout, s_status()} !== {1'b1, m_dout, m_status()}) begin
        bad++; $display("FAIL wrap_pair[%0d]: got %h want %h", i, {s_dv, s_dout, s_status()}, {1'b1, m_dout, m_status()});
      end
      total++;
      if ({f_dv, f_dout} !== {1'b1, sb[0]}) begin
        bad++; $display("FAIL wrap_fwft[%0d]: got %h want %h", i, {f_dv, f_dout}, {1'b1, sb[0]});
      end
    end
    total++;
    if ({saw_toggle, u_std.w_ptr_q, u_std.r_ptr_q} !== {1'b1, m_wptr, m_rptr}) begin
      bad++; $display("FAIL wrap_ptrs: got %h want %h", {saw_toggle, u_std.w_ptr_q, u_std.r_ptr_q}, {1'b1, m_wptr, m_rptr});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if ({s_dv, s_dout} !== {m_dv, m_dout}) begin
        bad++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, {s_dv, s_dout}, {m_dv, m_dout});
      end
    end
  endtask

  task automatic test_reset_mid();
    tick_rst(1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if ({s_cnt, s_unf, s_dout} !== {4'd5, 1'b1, 8'h60}) begin
      bad++; $display("FAIL pre_reset: got %h want %h", {s_cnt, s_unf, s_dout}, {4'd5, 1'b1, 8'h60});
    end
    tick_rst(1'b1);
    total++;
    if ({s_status(), s_dout, s_dv, s_ovf, s_unf} !== {8'h05, 8'h00, 3'b000}) begin
      bad++; $display("FAIL mid_reset: got %h want %h", {s_status(), s_dout, s_dv, s_ovf, s_unf}, {8'h05, 8'h00, 3'b000});
    end
    total++;
    if ({f_status(), f_dv} !== {8'h05, 1'b0}) begin
      bad++; $display("FAIL mid_reset_fwft: got %h want %h", {f_status(), f_dv}, {8'h05, 1'b0});
    end
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    tick(1'b1, 1'b0, 1'b1, 8'hCC);
    total++;
    if ({s_ovf, f_ovf, s_cnt} !== {m_ovf, 1'b1, 4'd8}) begin
      bad++; $display("FAIL set_beats_clear: got %h want %h", {s_ovf, f_ovf, s_cnt}, {m_ovf, 1'b1, 4'd8});
    end
    tick(1'b0, 1'b0, 1'b1, 8'h00);
    total++;
    if ({s_ovf, f_ovf} !== 2'b00) begin
      bad++; $display("FAIL clear_after: got %b want %b", {s_ovf, f_ovf}, 2'b00);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sync_fifo_ctl

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
Parametrised synchronous FIFO, the next generation of the BPSK datapath buffer. It adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- occupancy count output
- sticky overflow and underflow error flags

It sits between sample producers (modulator, symbol mapper) and consumers in the same clock domain.

Parameters:
- DEPTH, 8: number of entries. Power of two, >= 2.
- WIDTH, 8: data word width in bits.
- FWFT, 0: 0 = standard mode (data_out valid 1 cycle after an accepted read); 1 = head word presented on data_out whenever not empty.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Range 0..DEPTH-1.

Ports:
- clk_sig, input, 1: the block's only clock; all state updates on its rising edge.
- rst_sig, input, 1: synchronous, active-high reset.
- w_en_sig, input, 1: write request.
- r_en_sig, input, 1: read request (pop in FWFT mode).
- clr_err_sig, input, 1: clears the sticky error flags.
- data_in, input, WIDTH: write data.
- data_out, output, WIDTH: read data.
- data_valid, output, 1: standard mode: 1-cycle pulse, data_out holds a newly read word. FWFT mode: equals !empty.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

Behaviour:
- Reset (rst_sig=1 at a clock edge) sets:
  - w_ptr = r_ptr = 0, count = 0
  - data_out = 0, data_valid = 0
  - overflow = underflow = 0
  - resulting flags: empty=1, full=0, almost_empty=1, almost_full=0
- Reset dominates every other input in the same cycle. A reset mid-operation discards all stored words. Memory contents are not cleared.
- Pointers are PTR_W+1 bits, where PTR_W = $clog2(DEPTH). The MSB is a wrap bit.
  - full = wrap bits differ and low bits are equal.
  - empty = pointers are equal.
- Pointer increments wrap naturally modulo 2*DEPTH.
- Write acceptance: w_acc = w_en_sig & !full. On acceptance, mem[w_ptr low bits] <= data_in and w_ptr increments.
- Read acceptance: r_acc = r_en_sig & !empty. On acceptance, r_ptr increments.
- Full/empty decisions use the current cycle's flags only. There is no write-through-when-full and no read-of-same-cycle-write.
- count update: +1 if w_acc only; -1 if r_acc only; unchanged if both or neither. count equals w_ptr - r_ptr at all times.
- Simultaneous read and write:
  - when full: the read is accepted, the write is rejected and sets overflow.
  - when empty: the write is accepted, the read is rejected and sets underflow.
  - otherwise both are accepted and count is unchanged.
- Standard mode (FWFT=0):
  - On r_acc, data_out <= mem[r_ptr] at the same edge, and data_valid = 1 for the following cycle.
  - data_out holds its value otherwise; data_valid = 0 otherwise.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out = mem[r_ptr low bits] combinationally; data_valid = !empty.
  - A word written into an empty FIFO at edge N is visible on data_out after edge N.
  - r_acc advances to the next word after the edge.
  - data_out content while empty is don't-care.
- almost_full and almost_empty are combinational from registered count.
- Error flags:
  - overflow <= 1 on w_en_sig & full; underflow <= 1 on r_en_sig & empty.
  - Both clear on clr_err_sig. If a set condition and clr_err_sig occur in the same cycle, set wins.
  - Errors never corrupt pointers or count.

Decomposition:
- Package bpsk_fifo_pkg:
  - constants FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1
  - ptr_width(depth) function returning $clog2(depth)
  - elaboration-time parameter check: DEPTH is a power of two; AF_LEVEL and AE_LEVEL are within range
- Sub-module sync_fifo_mem:
  - DEPTH x WIDTH register array
  - one synchronous write port, one asynchronous read port
  - no reset
- sync_fifo_ctl holds the pointers, count, flags, output register and error logic.

Test Plan:
1. DEPTH=8, FWFT=0: write 0x11..0x88 on 8 consecutive cycles -> full=1 and count=8 after the 8th edge; almost_full=1 from count=6. A 9th write sets overflow=1 and count stays 8.
2. Standard-mode drain after test 1: r_en_sig held for 8 cycles -> data_out=0x11..0x88, each with a data_valid pulse 1 cycle after its read. Then empty=1 and almost_empty=1 from count<=2. A 9th read sets underflow=1.
3. FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 and data_valid=1 the cycle after the write. Pop it -> empty=1 next cycle.
4. Simultaneous read and write at count=4 -> count stays 4; output order preserved. At full, r+w -> count=7 and overflow=1. At empty, r+w -> count=1 and underflow=1.
5. Wrap-around: 20 write/read pairs at a random offset -> data order exact, pointer wrap bit toggles, no spurious full or empty.
6. rst_sig asserted at count=5 together with w_en_sig -> next cycle count=0, empty=1, data_out=0, errors=0. clr_err_sig and overflow set in the same cycle -> overflow remains 1.
